// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - four-crossing pedestrian WALK/DON'T WALK controller slaved to the vehicle lamps
// Optional audible chirp drive on PED_CHIRP_EN.
module ped_crossing_ctrl #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int WALK_TICKS     = 5000,
  parameter int FLASH_TICKS    = 3000,
  parameter int FLASH_HALF     = 250,
  parameter int CHIRP_HALF     = 100,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] btn,
  input  logic [3:0] veh_green,
  input  logic [3:0] veh_yellow,
  output logic [3:0] walk,
  output logic [3:0] dont_walk,
  output logic [3:0] req_pending,
  output logic [3:0] conflict,
  output logic [3:0] chirp
);

  typedef enum logic [1:0] {IDLE, WAIT, WALK, FLASH} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_TICKS);
  localparam logic [CNT_W-1:0] FLSH_LOAD = CNT_W'(FLASH_TICKS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_xing
    logic             deb_q;
    logic [CNT_W-1:0] dcnt_q;
    logic             press;
    logic             safe;
    logic             expire;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d, fcnt_q, fcnt_d;
    logic             dw_q, dw_d, pend_q, pend_d, req_q, req_d, conf_q, conf_d, walk_q;

    // Counter runs only while the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb_q  <= 1'b0;
        dcnt_q <= '0;
      end else if (sync2_q[i] == deb_q) begin
        dcnt_q <= '0;
      end else if (tick) begin
        if (dcnt_q >= DB_LAST) begin
          deb_q  <= sync2_q[i];
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_q + ONE;
        end
      end
    end

    assign press  = tick && (sync2_q[i] != deb_q) && (dcnt_q >= DB_LAST) && sync2_q[i];
    assign safe   = !veh_green[i] && !veh_yellow[i];
    assign expire = tick && (tmr_q == ONE);

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      fcnt_d  = fcnt_q;
      dw_d    = dw_q;
      pend_d  = pend_q;
      req_d   = req_q;
      conf_d  = conf_q;
      if ((state_q == WALK || state_q == FLASH) && !safe) begin
        state_d = IDLE;
        tmr_d   = '0;
        fcnt_d  = '0;
        dw_d    = 1'b1;
        pend_d  = 1'b0;
        req_d   = 1'b0;
        conf_d  = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            dw_d = 1'b1;
            if (press) begin
              state_d = WAIT;
              req_d   = 1'b1;
            end
          end
          WAIT: begin
            dw_d = 1'b1;
            if (safe) begin
              state_d = WALK;
              tmr_d   = WALK_LOAD;
              req_d   = 1'b0;
              dw_d    = 1'b0;
            end
          end
          WALK: begin
            if (expire) begin
              state_d = FLASH;
              tmr_d   = FLSH_LOAD;
              fcnt_d  = HALF_LOAD;
              dw_d    = 1'b1;
            end else if (tick && tmr_q != '0) begin
              tmr_d = tmr_q - ONE;
            end
          end
          FLASH: begin
            if (expire) begin
              state_d = pend_q ? WAIT : IDLE;
              tmr_d   = '0;
              fcnt_d  = '0;
              dw_d    = 1'b1;
              pend_d  = 1'b0;
            end else begin
              if (tick) begin
                if (tmr_q != '0) tmr_d = tmr_q - ONE;
                // Toggle on the tick that would empty the half-period counter.
                if (fcnt_q <= ONE) begin
                  dw_d   = ~dw_q;
                  fcnt_d = HALF_LOAD;
                end else begin
                  fcnt_d = fcnt_q - ONE;
                end
              end
              if (press) begin
                pend_d = 1'b1;
                req_d  = 1'b1;
              end
            end
          end
          default: begin
            state_d = IDLE;
            dw_d    = 1'b1;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        tmr_q   <= '0;
        fcnt_q  <= '0;
        dw_q    <= 1'b1;
        pend_q  <= 1'b0;
        req_q   <= 1'b0;
        conf_q  <= 1'b0;
        walk_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        fcnt_q  <= fcnt_d;
        dw_q    <= dw_d;
        pend_q  <= pend_d;
        req_q   <= req_d;
        conf_q  <= conf_d;
        walk_q  <= (state_d == WALK);
      end
    end

    assign walk[i]        = walk_q;
    assign dont_walk[i]   = dw_q;
    assign req_pending[i] = req_q;
    assign conflict[i]    = conf_q;

`ifdef PED_CHIRP_EN
    localparam logic [CNT_W-1:0] CHIRP_LOAD = CNT_W'(CHIRP_HALF);
    logic             chirp_q;
    logic [CNT_W-1:0] ccnt_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chirp_q <= 1'b0;
        ccnt_q  <= '0;
      end else if (state_d != WALK) begin
        chirp_q <= 1'b0;
        ccnt_q  <= '0;
      end else if (state_q != WALK) begin
        chirp_q <= 1'b1;
        ccnt_q  <= CHIRP_LOAD;
      end else if (tick) begin
        if (ccnt_q <= ONE) begin
          chirp_q <= ~chirp_q;
          ccnt_q  <= CHIRP_LOAD;
        end else begin
          ccnt_q <= ccnt_q - ONE;
        end
      end
    end

    assign chirp[i] = chirp_q;
`else
    assign chirp[i] = 1'b0;
`endif
  end

`ifndef PED_CHIRP_EN
  logic unused_chirp_cfg;
  assign unused_chirp_cfg = ^CHIRP_HALF;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - directed scoreboard bench for ped_crossing_ctrl
module tb_ped_crossing_ctrl;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] btn;
  logic [3:0] veh_green;
  logic [3:0] veh_yellow;
  logic [3:0] walk;
  logic [3:0] dont_walk;
  logic [3:0] req_pending;
  logic [3:0] conflict;
  logic [3:0] chirp;

  ped_crossing_ctrl #(
    .DEBOUNCE_TICKS(3),
    .WALK_TICKS    (10),
    .FLASH_TICKS   (6),
    .FLASH_HALF    (2),
    .CHIRP_HALF    (2),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .btn        (btn),
    .veh_green  (veh_green),
    .veh_yellow (veh_yellow),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .conflict   (conflict),
    .chirp      (chirp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic push(input string tag, input logic [3:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [3:0] obs);
    sb_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h expected nothing queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [5:0] flash_pat;
  logic [3:0] chirp_pat;

  initial begin
    reset      = 1'b1;
    tick       = 1'b1;
    btn        = 4'h0;
    veh_green  = 4'h0;
    veh_yellow = 4'h0;
    flash_pat  = 6'b110011;
`ifdef PED_CHIRP_EN
    chirp_pat  = 4'b0011;
`else
    chirp_pat  = 4'b0000;
`endif

    #2;
    push("rst_walk", 4'h0);      check(walk);
    push("rst_dont_walk", 4'hF); check(dont_walk);
    push("rst_req", 4'h0);       check(req_pending);
    push("rst_conflict", 4'h0);  check(conflict);
    push("rst_chirp", 4'h0);     check(chirp);
    #10 reset = 1'b0;
    step(1);

    // Scenario 1: bounces rejected, press accepted after 3 stable ticks, held off by green
    veh_green = 4'b0001;
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(3);
    push("bounce_no_req", 4'h0); check({3'b0, req_pending[0]});
    btn[0] = 1'b1;
    step(4);
    push("deb_early_req", 4'h0); check({3'b0, req_pending[0]});
    step(1);
    push("deb_req_set", 4'h1);   check({3'b0, req_pending[0]});
    push("green_no_walk", 4'h0); check({3'b0, walk[0]});
    step(4);
    push("green_hold_walk", 4'h0); check({3'b0, walk[0]});
    push("green_hold_req", 4'h1);  check({3'b0, req_pending[0]});

    // Scenario 2: safe edge -> WALK, 10 ticks, flashing DON'T WALK, IDLE
    veh_green = 4'h0;
    step(1);
    push("walk0_on", 4'h1);    check({3'b0, walk[0]});
    push("walk0_dw", 4'h0);    check({3'b0, dont_walk[0]});
    push("walk0_req_clr", 4'h0); check({3'b0, req_pending[0]});
    push("chirp0_0", {3'b0, chirp_pat[3]}); check({3'b0, chirp[0]});
    for (int k = 1; k < 4; k++) begin
      step(1);
      push("chirp0_seq", {3'b0, chirp_pat[3-k]}); check({3'b0, chirp[0]});
    end
    step(6);
    push("walk0_last", 4'h1);  check({3'b0, walk[0]});
    step(1);
    push("flash0_walk", 4'h0); check({3'b0, walk[0]});
    push("flash0_dw0", {3'b0, flash_pat[5]}); check({3'b0, dont_walk[0]});
    for (int k = 1; k < 6; k++) begin
      step(1);
      push("flash0_dw_seq", {3'b0, flash_pat[5-k]}); check({3'b0, dont_walk[0]});
    end
    step(1);
    push("idle0_dw", 4'h1);   check({3'b0, dont_walk[0]});
    push("idle0_walk", 4'h0); check({3'b0, walk[0]});
    step(2);
    push("idle0_dw_solid", 4'h1); check({3'b0, dont_walk[0]});
    push("idle0_chirp", 4'h0);    check({3'b0, chirp[0]});
    btn[0] = 1'b0;

    // Scenario 3: press during FLASH on crossing 2 re-queues a WALK
    btn[2] = 1'b1;
    step(5);
    push("x2_req", 4'h1); check({3'b0, req_pending[2]});
    btn[2] = 1'b0;
    step(1);
    push("x2_walk", 4'h1); check({3'b0, walk[2]});
    step(6);
    btn[2] = 1'b1;
    step(5);
    push("x2_flash_walk", 4'h0);  check({3'b0, walk[2]});
    push("x2_flash_req", 4'h1);   check({3'b0, req_pending[2]});
    step(5);
    push("x2_wait_walk", 4'h0);   check({3'b0, walk[2]});
    push("x2_wait_dw", 4'h1);     check({3'b0, dont_walk[2]});
    push("x2_wait_req", 4'h1);    check({3'b0, req_pending[2]});
    step(1);
    push("x2_rewalk", 4'h1);      check({3'b0, walk[2]});
    push("x2_rewalk_req", 4'h0);  check({3'b0, req_pending[2]});
    btn[2] = 1'b0;

    // Scenario 4: yellow on approach 1 during WALK -> sticky conflict
    btn[1] = 1'b1;
    step(5);
    btn[1] = 1'b0;
    step(1);
    push("x1_walk", 4'h1); check({3'b0, walk[1]});
    step(3);
    veh_yellow[1] = 1'b1;
    step(1);
    push("x1_conf_walk", 4'h0); check({3'b0, walk[1]});
    push("x1_conf_dw", 4'h1);   check({3'b0, dont_walk[1]});
    push("x1_conf_set", 4'h2);  check(conflict);
    veh_yellow[1] = 1'b0;
    step(3);
    push("x1_conf_held", 4'h2); check(conflict);
    push("x1_conf_idle", 4'h0); check({3'b0, walk[1]});

    // Scenario 5: asynchronous reset mid-WALK on crossings 0 and 3
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    step(5);
    btn = 4'h0;
    step(1);
    push("x03_walk", 4'b1001); check(walk);
    push("x03_dw", 4'b0110);   check(dont_walk);
    step(2);
    #2 reset = 1'b1;
    #1;
    push("arst_walk", 4'h0);      check(walk);
    push("arst_dont_walk", 4'hF); check(dont_walk);
    push("arst_req", 4'h0);       check(req_pending);
    push("arst_conflict", 4'h0);  check(conflict);
    push("arst_chirp", 4'h0);     check(chirp);
    #3 reset = 1'b0;
    step(3);
    push("post_rst_walk", 4'h0); check(walk);
    push("post_rst_dw", 4'hF);   check(dont_walk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
